mat_row_store: RTL

- Row-organised matrix storage that responds to the read-address/row-return and row write-back interface driven by the LU and triangular-inverse engines.
- A host port streams the matrix in row by row, then the block serves engine reads and writes, then streams the result back out.
- Replaces the behavioural matrix arrays used in simulation with synthesizable RTL.

---
 rtl/mat_row_store.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mat_row_store.sv
// Row-organised matrix store: host load, pipelined engine read/write-back
// service, then a flow-controlled dump of every stored row.
module mat_row_store #(
    parameter int SIZE     = 32,
    parameter int WIDTH    = 64,
    parameter int READ_LAT = 1,
    localparam int ROW_W   = SIZE * 2 * WIDTH,
    localparam int AW      = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [ROW_W-1:0] load_row_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [AW-1:0]    rd_addr_i,
    input  logic             rd_addr_valid_i,
    output logic [ROW_W-1:0] rd_row_o,
    output logic [AW-1:0]    rd_addr_o,
    output logic             rd_row_valid_o,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic             dump_start_i,
    output logic [ROW_W-1:0] dump_row_o,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic             dump_last_o,
    output logic             serving_o,
    output logic             addr_err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

    localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);
    localparam logic [AW:0]   SIZE_X = (AW + 1)'(SIZE);

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [ROW_W-1:0]  mem [SIZE];

    logic [READ_LAT-1:0] pipe_v;
    logic [AW-1:0]       pipe_a [READ_LAT];
    logic [ROW_W-1:0]    pipe_d [READ_LAT];

    logic abort, serve, load_en, rd_issue, rd_ok, wr_ok, wr_en;

    always_comb begin
        abort    = rst_i | flush_i;
        serve    = (state == SERVE);
        load_en  = load_ready_o && load_valid_i && !abort;
        rd_issue = serve && rd_addr_valid_i;
        rd_ok    = ({1'b0, rd_addr_i} < SIZE_X);
        wr_ok    = ({1'b0, wr_addr_i} < SIZE_X);
        wr_en    = serve && wr_valid_i && wr_ok && !abort;
    end

    assign load_ready_o   = (state == IDLE) || (state == LOAD);
    assign serving_o      = serve;
    assign wr_ready_o     = serve;
    assign rd_row_valid_o = pipe_v[READ_LAT-1];
    assign rd_addr_o      = pipe_a[READ_LAT-1];
    assign rd_row_o       = pipe_d[READ_LAT-1];

    // Storage is deliberately never reset; load and write-back are exclusive by state.
    always_ff @(posedge clk_i) begin
        if (load_en)
            mem[cnt] <= load_row_i;
        else if (wr_en)
            mem[wr_addr_i] <= wr_row_i;
    end

    // Stage 0 samples storage at issue, so a same-edge write is not seen (read-before-write).
    always_ff @(posedge clk_i) begin
        if (abort) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe_a[i] <= '0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_issue;
            if (rd_issue) begin
                pipe_a[0] <= rd_addr_i;
                pipe_d[0] <= rd_ok ? mem[rd_addr_i] : '0;
            end
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (abort) begin
            state        <= IDLE;
            cnt          <= '0;
            dump_row_o   <= '0;
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            addr_err_o   <= 1'b0;
        end else begin
            if (serve && ((rd_addr_valid_i && !rd_ok) || (wr_valid_i && !wr_ok)))
                addr_err_o <= 1'b1;
            case (state)
                IDLE, LOAD: begin
                    if (load_valid_i) begin
                        if (cnt == LAST) begin
                            state <= SERVE;
                            cnt   <= '0;
                        end else begin
                            state <= LOAD;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (dump_start_i) begin
                        state <= DUMP;
                        cnt   <= '0;
                    end
                end
                DUMP: begin
                    if (!dump_valid_o || dump_ready_i) begin
                        if (dump_valid_o && dump_last_o) begin
                            state        <= IDLE;
                            dump_valid_o <= 1'b0;
                            dump_last_o  <= 1'b0;
                        end else begin
                            dump_row_o   <= mem[cnt];
                            dump_valid_o <= 1'b1;
                            dump_last_o  <= (cnt == LAST);
                            cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
